muldiv_rs: RTL and testbench
============================

MULDIV_RS -- requirements
Module: muldiv_rs

Interface
REQ-001 Parameter DEPTH, default 4, number of reservation-station entries (power of two, 2..16).
REQ-002 Parameter NUM_CDB, default 2, number of CDB broadcast ports snooped for wakeup.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  pipeline flush (branch mispredict); discards all entries.
REQ-006 dispatch_valid  input  1  rename/dispatch presents a mul/div instruction.
REQ-007 dispatch_entry  input  rs_entry_t  funct3, rob_id, rd_addr, pd_addr, ps1_addr, ps2_addr, ps1_ready, ps2_ready.
REQ-008 dispatch_ready  output  1  station can accept a dispatch this cycle.
REQ-009 cdb  input  cdb_t[NUM_CDB]  result broadcasts; ready and pr_dest used for wakeup.
REQ-010 rs_entry_valid  output  1  an entry with both operands ready is presented to the divider.
REQ-011 rs_entry_dout  output  rs_entry_t  presented entry; ps1_addr/ps2_addr also drive regfile read ports.
REQ-012 issue_ready  input  1  divider accepts (its ready output).

Function
REQ-013 Each entry holds a valid bit, the rs_entry_t payload and, when MULDIV_RS_AGE_EN is defined, an age value.
REQ-014 dispatch_ready SHALL be 1 iff at least one entry is invalid, computed from registered state only, so a full station does not accept a dispatch in the cycle an entry issues.
REQ-015 Dispatch handshake: when dispatch_valid && dispatch_ready, the lowest-index free entry is written at the clock edge; dispatch_valid while dispatch_ready=0 is ignored and nothing is written.
REQ-016 A source tag equal to physical register 0 is marked ready at dispatch, regardless of the incoming ready bit.
REQ-017 Wakeup: for every valid entry and every port k, cdb[k].ready && cdb[k].pr_dest == psN_addr (N = 1, 2), with psN_addr nonzero, sets psN_ready at the edge.
REQ-018 A dispatching entry SHALL also be woken by a matching broadcast in the same cycle, so a broadcast concurrent with dispatch is never lost.
REQ-019 An entry is eligible for issue when it is valid and ps1_ready && ps2_ready.
REQ-020 rs_entry_valid is 1 iff any entry is eligible; rs_entry_dout is the selected eligible entry; both are combinational from registered state; wakeups take effect the cycle after the broadcast.
REQ-021 Issue handshake: when rs_entry_valid && issue_ready, the selected entry is invalidated at the edge; when issue_ready=0 nothing changes.
REQ-022 Dispatch and issue in the same cycle are independent; they never target the same entry.
REQ-023 flush: all valid bits clear at the edge; same-cycle dispatch and issue are discarded; rs_entry_valid=0 the following cycle.
REQ-024 When flush and rst are both high, rst takes precedence; the observable result is identical.

Reset
REQ-025 On rst, all valid bits and ages clear; next cycle dispatch_ready=1, rs_entry_valid=0.
REQ-026 rs_entry_dout is don't-care while rs_entry_valid=0; payload storage is not reset.
REQ-027 rst mid-operation discards all entries, including any entry being dispatched that cycle.

Configuration
REQ-028 Macro MULDIV_RS_AGE_EN defined: on dispatch, the new entry's age is set to 0 and every other valid entry's age increments, saturating at DEPTH-1.
REQ-029 With MULDIV_RS_AGE_EN defined, selection picks the eligible entry with the highest age; ties go to the lowest index.
REQ-030 Macro MULDIV_RS_AGE_EN undefined: no age storage exists, and selection picks the lowest-index eligible entry.

Structure
REQ-031 rs_entry_t, cdb_t and the mul/div funct3 constants live in rv32i_types.
REQ-032 One sub-module, muldiv_rs_select: combinational eligible-vector (plus ages) to one-hot grant and valid.

Verification
REQ-033 Reset, then dispatch 4 ready entries with issue_ready=0 -> dispatch_ready=0 after the 4th; a 5th dispatch is ignored; issue_ready=1 drains one entry per cycle.
REQ-034 Dispatch an entry with ps1_addr=7 not ready; cdb[1] broadcasts pr_dest=7 -> rs_entry_valid=1 exactly one cycle after the broadcast.
REQ-035 Dispatch with ps2_addr=9 not ready while cdb[0] broadcasts pr_dest=9 in the same cycle -> entry is eligible the next cycle.
REQ-036 AGE_EN defined: dispatch A (not ready), then B (ready), then wake A -> A issues before B; with AGE_EN undefined, the lowest-index entry issues first.
REQ-037 Three valid entries, then flush together with dispatch_valid=1 -> next cycle all entries are invalid, rs_entry_valid=0, dispatch_ready=1.
REQ-038 Dispatch a source with ps1_addr=0 and ps1_ready=0 -> entry is treated as ready and issues without any CDB broadcast.

Source files
------------

// File: rtl/muldiv_rs_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_rs_pkg
// Local helpers for the mul/div reservation station.
//   age_t       : per-entry age counter, wide enough for DEPTH up to 16
//   age_sat_inc : saturating age increment (used when MULDIV_RS_AGE_EN is set)
// ---------------------------------------------------------------------------
package muldiv_rs_pkg;

    localparam int AGE_W = 4;

    typedef logic [AGE_W-1:0] age_t;

    function automatic age_t age_sat_inc(input age_t a, input age_t lim);
        return (a >= lim) ? lim : a + age_t'(1);
    endfunction

endpackage

// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared RV32 pipeline types used by the rename/dispatch, reservation
// stations and the common data bus (CDB).
//   rs_entry_t : payload held by a reservation-station entry
//   cdb_t      : one result broadcast on the common data bus
//   F3_*       : funct3 encodings of the M-extension mul/div operations
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int AR_W  = 5;   // architectural register index
    localparam int PR_W  = 6;   // physical register index
    localparam int ROB_W = 4;   // reorder-buffer index

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef struct packed {
        logic [2:0]       funct3;
        logic [ROB_W-1:0] rob_id;
        logic [AR_W-1:0]  rd_addr;
        logic [PR_W-1:0]  pd_addr;
        logic [PR_W-1:0]  ps1_addr;
        logic [PR_W-1:0]  ps2_addr;
        logic             ps1_ready;
        logic             ps2_ready;
    } rs_entry_t;

    typedef struct packed {
        logic             ready;
        logic [ROB_W-1:0] rob_id;
        logic [PR_W-1:0]  pr_dest;
        logic [31:0]      rd_data;
    } cdb_t;

endpackage

// File: rtl/muldiv_rs_if.sv
// ---------------------------------------------------------------------------
// muldiv_rs_if
// Bundle between rename/dispatch, the CDB, the divider and the mul/div
// reservation station.
//   flush                          : pipeline flush (mispredict)
//   dispatch_valid/entry/ready     : dispatch handshake into the station
//   cdb[NUM_CDB]                   : result broadcasts used for wakeup
//   rs_entry_valid/dout, issue_ready : issue handshake towards the divider
// master = dispatch/CDB/divider side, slave = reservation station.
// ---------------------------------------------------------------------------
interface muldiv_rs_if #(
    parameter int NUM_CDB = 2
);
    import rv32i_types::*;

    logic      flush;
    logic      dispatch_valid;
    rs_entry_t dispatch_entry;
    logic      dispatch_ready;
    cdb_t      cdb [NUM_CDB];
    logic      rs_entry_valid;
    rs_entry_t rs_entry_dout;
    logic      issue_ready;

    modport master (
        output flush, dispatch_valid, dispatch_entry, cdb, issue_ready,
        input  dispatch_ready, rs_entry_valid, rs_entry_dout
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_entry, cdb, issue_ready,
        output dispatch_ready, rs_entry_valid, rs_entry_dout
    );

endinterface

// File: rtl/muldiv_rs_select.sv
// ---------------------------------------------------------------------------
// muldiv_rs_select
// Combinational issue picker: eligible vector -> one-hot grant + valid.
// With MULDIV_RS_AGE_EN defined the oldest (highest age) eligible entry wins,
// ties to the lowest index; otherwise the lowest-index eligible entry wins.
// Ports:
//   elig_i  : per-entry eligible flags
//   age_i   : per-entry ages (only with MULDIV_RS_AGE_EN)
//   grant_o : one-hot selected entry
//   valid_o : any entry eligible
// ---------------------------------------------------------------------------
module muldiv_rs_select
    import muldiv_rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] elig_i,
`ifdef MULDIV_RS_AGE_EN
    input  age_t             age_i [DEPTH],
`endif
    output logic [DEPTH-1:0] grant_o,
    output logic             valid_o
);

    logic found;
`ifdef MULDIV_RS_AGE_EN
    age_t best_age;
`endif

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
`ifdef MULDIV_RS_AGE_EN
        best_age = '0;
        // Strict '>' keeps the lower index on equal ages.
        for (int i = 0; i < DEPTH; i++) begin
            if (elig_i[i] && (!found || age_i[i] > best_age)) begin
                found      = 1'b1;
                best_age   = age_i[i];
                grant_o    = '0;
                grant_o[i] = 1'b1;
            end
        end
`else
        for (int i = 0; i < DEPTH; i++) begin
            if (elig_i[i] && !found) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
            end
        end
`endif
        valid_o = found;
    end

endmodule

// File: rtl/muldiv_rs.sv
// ---------------------------------------------------------------------------
// muldiv_rs
// Reservation station in front of the mul/div unit. Holds DEPTH entries,
// wakes source operands from NUM_CDB result broadcasts and presents one
// ready entry per cycle to the divider.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (clears valid bits and ages)
//   bus  : muldiv_rs_if.slave (dispatch, CDB, issue and flush signals)
// Optional feature: define MULDIV_RS_AGE_EN for oldest-first selection
// (per-entry saturating age counters); default is lowest-index selection.
// ---------------------------------------------------------------------------
module muldiv_rs
    import rv32i_types::*;
    import muldiv_rs_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_rs_if.slave  bus
);

    logic [DEPTH-1:0] valid_q, valid_d;
    rs_entry_t        entry_q [DEPTH];
    rs_entry_t        entry_d [DEPTH];
`ifdef MULDIV_RS_AGE_EN
    localparam age_t AGE_MAX = age_t'(DEPTH - 1);
    age_t             age_q [DEPTH];
    age_t             age_d [DEPTH];
`endif

    logic [DEPTH-1:0] free_oh, elig, grant;
    logic [DEPTH-1:0] wake1, wake2;
    logic             dwake1, dwake2;
    logic             sel_valid, do_dispatch, do_issue, free_found;
    rs_entry_t        disp_entry;

    // Ready/accept decisions depend on registered state only.
    assign bus.dispatch_ready = ~&valid_q;
    assign do_dispatch        = bus.dispatch_valid & bus.dispatch_ready;
    assign do_issue           = sel_valid & bus.issue_ready;

    // Lowest-index free slot.
    always_comb begin
        free_oh    = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_oh[i] = 1'b1;
            end
        end
    end

    // Tag matches against every broadcast, for stored and incoming entries.
    // Physical register 0 never matches; it is always considered ready.
    always_comb begin
        wake1  = '0;
        wake2  = '0;
        dwake1 = 1'b0;
        dwake2 = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (bus.cdb[k].ready) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entry_q[i].ps1_addr != '0 && bus.cdb[k].pr_dest == entry_q[i].ps1_addr)
                        wake1[i] = 1'b1;
                    if (entry_q[i].ps2_addr != '0 && bus.cdb[k].pr_dest == entry_q[i].ps2_addr)
                        wake2[i] = 1'b1;
                end
                if (bus.dispatch_entry.ps1_addr != '0 &&
                    bus.cdb[k].pr_dest == bus.dispatch_entry.ps1_addr)
                    dwake1 = 1'b1;
                if (bus.dispatch_entry.ps2_addr != '0 &&
                    bus.cdb[k].pr_dest == bus.dispatch_entry.ps2_addr)
                    dwake2 = 1'b1;
            end
        end
    end

    always_comb begin
        disp_entry = bus.dispatch_entry;
        if (bus.dispatch_entry.ps1_addr == '0 || dwake1) disp_entry.ps1_ready = 1'b1;
        if (bus.dispatch_entry.ps2_addr == '0 || dwake2) disp_entry.ps2_ready = 1'b1;
    end

    // Issue selection
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            elig[i] = valid_q[i] & entry_q[i].ps1_ready & entry_q[i].ps2_ready;
    end

    muldiv_rs_select #(
        .DEPTH   (DEPTH)
    ) u_select (
        .elig_i  (elig),
`ifdef MULDIV_RS_AGE_EN
        .age_i   (age_q),
`endif
        .grant_o (grant),
        .valid_o (sel_valid)
    );

    assign bus.rs_entry_valid = sel_valid;

    always_comb begin
        bus.rs_entry_dout = '0;
        for (int i = 0; i < DEPTH; i++)
            if (grant[i]) bus.rs_entry_dout = entry_q[i];
    end

    // Next state: wakeup, issue, dispatch, then flush overrides validity.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (valid_q[i] && wake1[i]) entry_d[i].ps1_ready = 1'b1;
            if (valid_q[i] && wake2[i]) entry_d[i].ps2_ready = 1'b1;
        end
        if (do_issue) valid_d = valid_d & ~grant;
        if (do_dispatch) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (free_oh[i]) begin
                    entry_d[i] = disp_entry;
                    valid_d[i] = 1'b1;
                end
            end
        end
        if (bus.flush) valid_d = '0;
    end

`ifdef MULDIV_RS_AGE_EN
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (do_dispatch) begin
                if (free_oh[i])      age_d[i] = '0;
                else if (valid_q[i]) age_d[i] = age_sat_inc(age_q[i], AGE_MAX);
            end
        end
    end
`endif

    // Control state: reset applies here only.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
`ifdef MULDIV_RS_AGE_EN
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
`endif
        end else begin
            valid_q <= valid_d;
`ifdef MULDIV_RS_AGE_EN
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
`endif
        end
    end

    // Payload storage is not reset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end

endmodule

// File: tb/tb_muldiv_rs.sv
// ---------------------------------------------------------------------------
// tb_muldiv_rs
// Self-checking bench for muldiv_rs: directed scenarios followed by random
// traffic, compared every cycle against a slot-level reference model.
// Works with MULDIV_RS_AGE_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_muldiv_rs;
    import rv32i_types::*;

    localparam int DEPTH   = 4;
    localparam int NUM_CDB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_rs_if #(.NUM_CDB(NUM_CDB)) bus ();

    muldiv_rs #(
        .DEPTH   (DEPTH),
        .NUM_CDB (NUM_CDB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: slots with valid flag, payload and dispatch sequence
    // number. Age = later dispatches seen, capped at DEPTH-1.
    bit        m_vld [DEPTH];
    rs_entry_t m_ent [DEPTH];
    int        m_seq [DEPTH];
    int        m_ndisp;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    endfunction

    function automatic bit model_dready();
        for (int i = 0; i < DEPTH; i++) if (!m_vld[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_sel();
        int best = -1;
        int best_age = 0;
        int age;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_ent[i].ps1_ready && m_ent[i].ps2_ready) begin
`ifdef MULDIV_RS_AGE_EN
                age = m_ndisp - m_seq[i] - 1;
                if (age > DEPTH - 1) age = DEPTH - 1;
`else
                age = 0;
`endif
                if (best < 0 || age > best_age) begin
                    best = i;
                    best_age = age;
                end
            end
        end
        return best;
    endfunction

    function automatic bit hit(input logic [PR_W-1:0] a, input cdb_t c0, input cdb_t c1);
        if (a == 0) return 1'b0;
        return (c0.ready && c0.pr_dest == a) || (c1.ready && c1.pr_dest == a);
    endfunction

    function automatic void model_step(input logic r, input logic f, input logic dv,
                                       input rs_entry_t de, input cdb_t c0, input cdb_t c1,
                                       input logic ir);
        bit dr;
        int sel;
        int fr = -1;
        rs_entry_t ne;
        if (r) begin model_reset(); return; end
        if (f) begin model_reset(); return; end
        dr  = model_dready();
        sel = model_sel();
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) fr = i;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i]) begin
                if (hit(m_ent[i].ps1_addr, c0, c1)) m_ent[i].ps1_ready = 1'b1;
                if (hit(m_ent[i].ps2_addr, c0, c1)) m_ent[i].ps2_ready = 1'b1;
            end
        end
        if (ir && sel >= 0) m_vld[sel] = 1'b0;
        if (dv && dr) begin
            ne = de;
            if (de.ps1_addr == 0 || hit(de.ps1_addr, c0, c1)) ne.ps1_ready = 1'b1;
            if (de.ps2_addr == 0 || hit(de.ps2_addr, c0, c1)) ne.ps2_ready = 1'b1;
            m_ent[fr] = ne;
            m_vld[fr] = 1'b1;
            m_seq[fr] = m_ndisp;
            m_ndisp++;
        end
    endfunction

    // One clock: check outputs against the model, drive inputs, advance.
    task automatic step(input logic r, input logic f, input logic dv, input rs_entry_t de,
                        input cdb_t c0, input cdb_t c1, input logic ir);
        int sel;
        sel = model_sel();
        check("dispatch_ready", 64'(bus.dispatch_ready), 64'(model_dready()));
        check("rs_entry_valid", 64'(bus.rs_entry_valid), 64'(sel >= 0));
        if (sel >= 0) check("rs_entry_dout", 64'(bus.rs_entry_dout), 64'(m_ent[sel]));
        rst                = r;
        bus.flush          = f;
        bus.dispatch_valid = dv;
        bus.dispatch_entry = de;
        bus.cdb[0]         = c0;
        bus.cdb[1]         = c1;
        bus.issue_ready    = ir;
        model_step(r, f, dv, de, c0, c1, ir);
        @(posedge clk);
        #1;
    endtask

    function automatic rs_entry_t mk(input int rob, input int p1, input bit r1,
                                     input int p2, input bit r2);
        rs_entry_t e;
        e.funct3    = 3'(rob);
        e.rob_id    = ROB_W'(rob);
        e.rd_addr   = AR_W'(rob + 1);
        e.pd_addr   = PR_W'(rob + 20);
        e.ps1_addr  = PR_W'(p1);
        e.ps2_addr  = PR_W'(p2);
        e.ps1_ready = r1;
        e.ps2_ready = r2;
        return e;
    endfunction

    function automatic cdb_t bc(input int tag);
        cdb_t c;
        c.ready   = 1'b1;
        c.rob_id  = '0;
        c.pr_dest = PR_W'(tag);
        c.rd_data = 32'hDEAD_0000 + 32'(tag);
        return c;
    endfunction

    initial begin
        rs_entry_t nul;
        cdb_t      nc;
        rs_entry_t re;
        cdb_t      rc0, rc1;
        nul = '0;
        nc  = '0;
        m_ndisp = 0;
        model_reset();

        rst                = 1'b1;
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_entry = nul;
        bus.cdb[0]         = nc;
        bus.cdb[1]         = nc;
        bus.issue_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dready", 64'(bus.dispatch_ready), 64'd1);
        check("rst_valid",  64'(bus.rs_entry_valid), 64'd0);

        // Fill with four ready entries, fifth ignored, then drain.
        for (int i = 0; i < 4; i++) step(0, 0, 1, mk(i + 1, 3, 1, 4, 1), nc, nc, 0);
        check("full_dready", 64'(bus.dispatch_ready), 64'd0);
        step(0, 0, 1, mk(9, 3, 1, 4, 1), nc, nc, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, nul, nc, nc, 1);
        check("drained_valid", 64'(bus.rs_entry_valid), 64'd0);

        // Wakeup via cdb[1], visible one cycle after the broadcast.
        step(0, 0, 1, mk(5, 7, 0, 3, 1), nc, nc, 0);
        step(0, 0, 0, nul, nc, bc(7), 0);
        check("wake_latency", 64'(bus.rs_entry_valid), 64'd1);
        step(0, 0, 0, nul, nc, nc, 1);

        // Broadcast concurrent with dispatch is not lost.
        step(0, 0, 1, mk(6, 0, 1, 9, 0), bc(9), nc, 0);
        check("disp_wake", 64'(bus.rs_entry_valid), 64'd1);
        step(0, 0, 0, nul, nc, nc, 1);

        // A (waiting) then B (ready); after waking A, A issues first.
        step(0, 0, 1, mk(10, 5, 0, 0, 0), nc, nc, 0);
        step(0, 0, 1, mk(11, 2, 1, 3, 1), nc, nc, 0);
        step(0, 0, 0, nul, bc(5), nc, 0);
        check("age_first", 64'(bus.rs_entry_dout.rob_id), 64'd10);
        step(0, 0, 0, nul, nc, nc, 1);
        check("age_second", 64'(bus.rs_entry_dout.rob_id), 64'd11);
        step(0, 0, 0, nul, nc, nc, 1);

        // Flush with three entries plus a concurrent dispatch and issue.
        for (int i = 0; i < 3; i++) step(0, 0, 1, mk(i + 1, 1, 1, 2, 1), nc, nc, 0);
        step(0, 1, 1, mk(12, 1, 1, 2, 1), nc, nc, 1);
        check("flush_valid",  64'(bus.rs_entry_valid), 64'd0);
        check("flush_dready", 64'(bus.dispatch_ready), 64'd1);

        // Register 0 sources are ready regardless of the incoming bit.
        step(0, 0, 1, mk(13, 0, 0, 0, 0), nc, nc, 0);
        check("x0_ready", 64'(bus.rs_entry_valid), 64'd1);
        step(0, 0, 0, nul, nc, nc, 1);

        // rst and flush together, with a dispatch in flight.
        step(0, 0, 1, mk(14, 1, 1, 1, 1), nc, nc, 0);
        step(1, 1, 1, mk(15, 1, 1, 1, 1), nc, nc, 0);
        check("rst_flush_valid", 64'(bus.rs_entry_valid), 64'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            re  = mk($urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            rc0 = bc($urandom_range(0, 7));
            rc1 = bc($urandom_range(0, 7));
            rc0.ready = ($urandom_range(0, 2) == 0);
            rc1.ready = ($urandom_range(0, 2) == 0);
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), re, rc0, rc1, 1'($urandom_range(0, 3) != 0));
        end
        step(0, 0, 0, nul, nc, nc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
